vc_fifo_bank: RTL and testbench
===============================

VC_FIFO_BANK -- requirements
Module: vc_fifo_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, width of one stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, per-VC depth DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter NUM_VC, default 2, number of independent virtual-channel FIFOs (1..8).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 init  input  1  synchronous soft clear, active-low.
REQ-007 wr_enable  input  1  write request for the word on data_in.
REQ-008 wr_vc  input  3  target VC index of the write.
REQ-009 data_in  input  DATA_WIDTH  write data.
REQ-010 rd_enable  input  NUM_VC  per-VC read request.
REQ-011 umbral_af  input  NUM_VC*ADDR_WIDTH  per-VC almost-full threshold, VC v in bits [v*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 umbral_ae  input  NUM_VC*ADDR_WIDTH  per-VC almost-empty threshold, same packing.
REQ-013 data_out  output  NUM_VC*DATA_WIDTH  registered read data per VC.
REQ-014 data_head  output  NUM_VC*DATA_WIDTH  combinational head-of-queue word per VC (peek for the arbiter).
REQ-015 count  output  NUM_VC*(ADDR_WIDTH+1)  registered occupancy per VC, 0..DEPTH.
REQ-016 full, empty, almost_full, almost_empty  output  NUM_VC each  per-VC status flags.
REQ-017 error  output  NUM_VC  per-VC sticky overflow/underflow flag.

Function
REQ-018 Each VC SHALL own a DEPTH-entry memory, wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap modulo DEPTH) and count (ADDR_WIDTH+1 bits).
REQ-019 full[v] = (count[v] == DEPTH); empty[v] = (count[v] == 0); both decoded from registered count only.
REQ-020 almost_full[v] = (count[v] >= DEPTH - umbral_af[v]) and not full[v]; almost_empty[v] = (count[v] <= umbral_ae[v]) and not empty[v].
REQ-021 Write accepted when wr_enable=1, wr_vc < NUM_VC, full[wr_vc]=0: mem[wr_ptr] <= data_in, wr_ptr +1.
REQ-022 Write with wr_vc >= NUM_VC SHALL be discarded with no state change and no error.
REQ-023 Write to a full VC SHALL be discarded and set error[wr_vc], even if that VC is read in the same cycle.
REQ-024 Read accepted when rd_enable[v]=1 and empty[v]=0: data_out[v] <= mem[rd_ptr], rd_ptr +1; latency 1 cycle.
REQ-025 Read on an empty VC SHALL be ignored and set error[v], even if that VC is written in the same cycle.
REQ-026 data_out[v] SHALL be 0 in any cycle following no accepted read on v.
REQ-027 count[v] SHALL +1 on accepted write only, -1 on accepted read only, hold on both or neither.
REQ-028 Reads on several VCs and one write SHALL all be serviced in the same cycle.
REQ-029 data_head[v] = mem[rd_ptr[v]]; undefined content when empty[v]=1.
REQ-030 error[v] once set SHALL hold until reset or init low.
REQ-031 Thresholds SHALL be sampled combinationally every cycle; changing them affects flags immediately.

Reset
REQ-032 reset=0 SHALL asynchronously clear all pointers, count, data_out and error; flags then read empty=1, others 0.
REQ-033 init=0 SHALL synchronously apply the same clear at the next edge, overriding any concurrent write/read.
REQ-034 Memory contents SHALL NOT be cleared by reset or init.

Verification
REQ-035 Reset then write 0x11,0x22,0x33 to VC0 -> count0=3, data_head0=0x11; rd_enable=01 -> next cycle data_out0=0x11, count0=2.
REQ-036 16 writes to VC1 (ADDR_WIDTH=4) -> full[1]=1, count1=16; 17th write dropped, error[1]=1, count1=16; 16 reads return data in order, empty[1]=1.
REQ-037 umbral_af=3, umbral_ae=2 on VC0: count 2 -> almost_empty=1; count 13 -> almost_full=1; count 16 -> almost_full=0, full=1.
REQ-038 Simultaneous write+read on VC0 at count 5 -> count stays 5, pointers both advance; across 20 such cycles pointers wrap with data intact.
REQ-039 rd_enable=11 with VC1 empty -> VC0 read served, error[1]=1, data_out1=0; init=0 for one cycle -> error=00, count=0.
REQ-040 reset asserted mid-stream (asynchronous, between edges) -> outputs clear before next edge; wr_vc=5 write when NUM_VC=2 -> no change.

Source files
------------

// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC independent virtual-channel FIFOs sharing a single write port.
// Each VC has its own read port, registered read data, occupancy and status flags.
module vc_fifo_bank #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_VC     = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           init,
    input  logic                           wr_enable,
    input  logic [2:0]                     wr_vc,
    input  logic [DATA_WIDTH-1:0]          data_in,
    input  logic [NUM_VC-1:0]              rd_enable,
    input  logic [NUM_VC*ADDR_WIDTH-1:0]   umbral_af,
    input  logic [NUM_VC*ADDR_WIDTH-1:0]   umbral_ae,
    output logic [NUM_VC*DATA_WIDTH-1:0]   data_out,
    output logic [NUM_VC*DATA_WIDTH-1:0]   data_head,
    output logic [NUM_VC*(ADDR_WIDTH+1)-1:0] count,
    output logic [NUM_VC-1:0]              full,
    output logic [NUM_VC-1:0]              empty,
    output logic [NUM_VC-1:0]              almost_full,
    output logic [NUM_VC-1:0]              almost_empty,
    output logic [NUM_VC-1:0]              error
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    word_t             mem_q    [NUM_VC][DEPTH];
    ptr_t              wr_ptr_q [NUM_VC];
    ptr_t              wr_ptr_d [NUM_VC];
    ptr_t              rd_ptr_q [NUM_VC];
    ptr_t              rd_ptr_d [NUM_VC];
    cnt_t              count_q  [NUM_VC];
    cnt_t              count_d  [NUM_VC];
    word_t             dout_q   [NUM_VC];
    word_t             dout_d   [NUM_VC];
    logic [NUM_VC-1:0] error_q;
    logic [NUM_VC-1:0] error_d;

    logic [NUM_VC-1:0] full_w;
    logic [NUM_VC-1:0] empty_w;
    logic [NUM_VC-1:0] wr_hit;
    logic [NUM_VC-1:0] wr_acc;
    logic [NUM_VC-1:0] rd_acc;

    function automatic logic almost_full_f(input cnt_t c, input ptr_t th);
        return (c >= (DEPTH_C - cnt_t'(th))) && (c != DEPTH_C);
    endfunction

    function automatic logic almost_empty_f(input cnt_t c, input ptr_t th);
        return (c <= cnt_t'(th)) && (c != '0);
    endfunction

    // A write whose VC index is out of range matches no wr_hit bit and is dropped silently.
    always_comb begin
        full_w  = '0;
        empty_w = '0;
        wr_hit  = '0;
        wr_acc  = '0;
        rd_acc  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full_w[v]  = (count_q[v] == DEPTH_C);
            empty_w[v] = (count_q[v] == '0);
            wr_hit[v]  = wr_enable && (wr_vc == 3'(v));
            wr_acc[v]  = wr_hit[v] && !full_w[v];
            rd_acc[v]  = rd_enable[v] && !empty_w[v];
        end
    end

    always_comb begin
        error_d = error_q | (wr_hit & full_w) | (rd_enable & empty_w);
        for (int v = 0; v < NUM_VC; v++) begin
            wr_ptr_d[v] = wr_ptr_q[v];
            rd_ptr_d[v] = rd_ptr_q[v];
            count_d[v]  = count_q[v];
            dout_d[v]   = '0;
            if (wr_acc[v]) begin
                wr_ptr_d[v] = wr_ptr_q[v] + ptr_t'(1);
            end
            if (rd_acc[v]) begin
                rd_ptr_d[v] = rd_ptr_q[v] + ptr_t'(1);
                dout_d[v]   = mem_q[v][rd_ptr_q[v]];
            end
            case ({wr_acc[v], rd_acc[v]})
                2'b10:   count_d[v] = count_q[v] + cnt_t'(1);
                2'b01:   count_d[v] = count_q[v] - cnt_t'(1);
                default: count_d[v] = count_q[v];
            endcase
        end
        // Soft clear wins over any concurrent traffic.
        if (!init) begin
            error_d = '0;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_d[v] = '0;
                rd_ptr_d[v] = '0;
                count_d[v]  = '0;
                dout_d[v]   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                count_q[v]  <= '0;
                dout_q[v]   <= '0;
            end
        end else begin
            error_q <= error_d;
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= wr_ptr_d[v];
                rd_ptr_q[v] <= rd_ptr_d[v];
                count_q[v]  <= count_d[v];
                dout_q[v]   <= dout_d[v];
            end
        end
    end

    // Storage is deliberately left out of reset and soft clear.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (init && wr_acc[v]) begin
                mem_q[v][wr_ptr_q[v]] <= data_in;
            end
        end
    end

    always_comb begin
        data_out     = '0;
        data_head    = '0;
        count        = '0;
        almost_full  = '0;
        almost_empty = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            data_out[v*DATA_WIDTH +: DATA_WIDTH] = dout_q[v];
            data_head[v*DATA_WIDTH +: DATA_WIDTH] = mem_q[v][rd_ptr_q[v]];
            count[v*CW +: CW] = count_q[v];
            almost_full[v]  = almost_full_f(count_q[v], umbral_af[v*ADDR_WIDTH +: ADDR_WIDTH]);
            almost_empty[v] = almost_empty_f(count_q[v], umbral_ae[v*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    assign full  = full_w;
    assign empty = empty_w;
    assign error = error_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Bench for vc_fifo_bank: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_vc_fifo_bank;

    localparam int DW    = 6;
    localparam int AW    = 4;
    localparam int NV    = 2;
    localparam int DEPTH = 16;
    localparam int CW    = AW + 1;
    localparam int TW    = NV * AW;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              init = 1'b1;
    logic              wr_enable = 1'b0;
    logic [2:0]        wr_vc = '0;
    logic [DW-1:0]     data_in = '0;
    logic [NV-1:0]     rd_enable = '0;
    logic [TW-1:0]     umbral_af = '0;
    logic [TW-1:0]     umbral_ae = '0;
    logic [NV*DW-1:0]  data_out;
    logic [NV*DW-1:0]  data_head;
    logic [NV*CW-1:0]  count;
    logic [NV-1:0]     full, empty, almost_full, almost_empty, error;

    int checks = 0;
    int errors = 0;

    int mq [NV][$];
    int m_err  [NV];
    int m_dout [NV];

    vc_fifo_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VC(NV)) dut (
        .clk(clk), .reset(reset), .init(init),
        .wr_enable(wr_enable), .wr_vc(wr_vc), .data_in(data_in),
        .rd_enable(rd_enable), .umbral_af(umbral_af), .umbral_ae(umbral_ae),
        .data_out(data_out), .data_head(data_head), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int v);
        return 32'(count[v*CW +: CW]);
    endfunction

    function automatic logic [31:0] dout_of(input int v);
        return 32'(data_out[v*DW +: DW]);
    endfunction

    function automatic logic [31:0] head_of(input int v);
        return 32'(data_head[v*DW +: DW]);
    endfunction

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            m_err[v]  = 0;
            m_dout[v] = 0;
        end
    endtask

    task automatic model_step();
        for (int v = 0; v < NV; v++) begin
            bit was_full, was_empty, wr_here;
            was_full  = (mq[v].size() == DEPTH);
            was_empty = (mq[v].size() == 0);
            wr_here   = wr_enable && (int'(wr_vc) == v);
            if (wr_here && was_full) m_err[v] = 1;
            if (rd_enable[v] && was_empty) m_err[v] = 1;
            m_dout[v] = 0;
            if (rd_enable[v] && !was_empty) m_dout[v] = mq[v].pop_front();
            if (wr_here && !was_full) mq[v].push_back(int'(data_in));
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset || !init) model_clear();
            else model_step();
        end
    end

    initial begin
        int n, af, ae;
        forever begin
            @(negedge clk);
            for (int v = 0; v < NV; v++) begin
                n  = mq[v].size();
                af = int'(umbral_af[v*AW +: AW]);
                ae = int'(umbral_ae[v*AW +: AW]);
                chk($sformatf("count[%0d]", v), cnt_of(v), n);
                chk($sformatf("full[%0d]", v), 32'(full[v]), 32'(n == DEPTH));
                chk($sformatf("empty[%0d]", v), 32'(empty[v]), 32'(n == 0));
                chk($sformatf("almost_full[%0d]", v), 32'(almost_full[v]),
                    32'((n >= DEPTH - af) && (n != DEPTH)));
                chk($sformatf("almost_empty[%0d]", v), 32'(almost_empty[v]),
                    32'((n <= ae) && (n != 0)));
                chk($sformatf("error[%0d]", v), 32'(error[v]), m_err[v]);
                chk($sformatf("data_out[%0d]", v), dout_of(v), m_dout[v]);
                if (n > 0) chk($sformatf("data_head[%0d]", v), head_of(v), mq[v][0]);
            end
        end
    end

    task automatic step(input logic we, input logic [2:0] vc, input logic [DW-1:0] d,
                        input logic [NV-1:0] rd);
        wr_enable = we;
        wr_vc     = vc;
        data_in   = d;
        rd_enable = rd;
        @(posedge clk);
        #1;
        wr_enable = 1'b0;
        rd_enable = '0;
    endtask

    task automatic pulse_init();
        init = 1'b0;
        @(posedge clk);
        #1;
        init = 1'b1;
    endtask

    initial begin
        int wp, rp;
        umbral_af = {4'd3, 4'd3};
        umbral_ae = {4'd2, 4'd2};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_empty", 32'(empty), 32'h3);
        chk("reset_count", 32'(count), 0);
        reset = 1'b1;

        // Three writes then one read on VC0
        step(1'b1, 3'd0, 6'h11, 2'b00);
        step(1'b1, 3'd0, 6'h22, 2'b00);
        step(1'b1, 3'd0, 6'h33, 2'b00);
        chk("lit_count0_3", cnt_of(0), 3);
        chk("lit_head0", head_of(0), 32'h11);
        step(1'b0, 3'd0, 6'h00, 2'b01);
        chk("lit_dout0_11", dout_of(0), 32'h11);
        chk("lit_count0_2", cnt_of(0), 2);

        // Fill VC1, overflow, drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 3'd1, 6'(i + 1), 2'b00);
        chk("lit_full1", 32'(full[1]), 1);
        chk("lit_count1_16", cnt_of(1), 16);
        step(1'b1, 3'd1, 6'h3F, 2'b00);
        chk("lit_err1_ovf", 32'(error[1]), 1);
        chk("lit_count1_hold", cnt_of(1), 16);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 3'd0, 6'h00, 2'b10);
            chk("lit_drain1", dout_of(1), 32'(i + 1));
        end
        chk("lit_empty1", 32'(empty[1]), 1);

        // Thresholds af=3, ae=2 on VC0 which holds 2 words
        chk("lit_ae0_at2", 32'(almost_empty[0]), 1);
        for (int i = 0; i < 11; i++) step(1'b1, 3'd0, 6'(i + 40), 2'b00);
        chk("lit_af0_at13", 32'(almost_full[0]), 1);
        chk("lit_ae0_at13", 32'(almost_empty[0]), 0);
        for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 6'(i + 60), 2'b00);
        chk("lit_af0_at16", 32'(almost_full[0]), 0);
        chk("lit_full0_at16", 32'(full[0]), 1);

        pulse_init();
        chk("lit_init_err", 32'(error), 0);
        chk("lit_init_count", 32'(count), 0);

        // Simultaneous write+read at occupancy 5, wrapping the pointers
        for (int i = 0; i < 5; i++) step(1'b1, 3'd0, 6'(i + 1), 2'b00);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 3'd0, 6'(k + 6), 2'b01);
            chk("lit_wr_rd_dout", dout_of(0), 32'(k + 1));
            chk("lit_wr_rd_count", cnt_of(0), 5);
        end

        // Read both VCs with VC1 empty
        pulse_init();
        step(1'b1, 3'd0, 6'h2A, 2'b00);
        step(1'b0, 3'd0, 6'h00, 2'b11);
        chk("lit_rd11_dout0", dout_of(0), 32'h2A);
        chk("lit_rd11_dout1", dout_of(1), 0);
        chk("lit_rd11_err", 32'(error), 32'h2);
        pulse_init();
        chk("lit_init2_err", 32'(error), 0);
        chk("lit_init2_count", 32'(count), 0);

        // Asynchronous reset between edges
        step(1'b1, 3'd0, 6'h07, 2'b00);
        step(1'b1, 3'd0, 6'h09, 2'b00);
        step(1'b0, 3'd0, 6'h00, 2'b01);
        chk("lit_pre_rst_dout", dout_of(0), 7);
        #2 reset = 1'b0;
        #1;
        chk("lit_arst_count", 32'(count), 0);
        chk("lit_arst_dout", 32'(data_out), 0);
        chk("lit_arst_empty", 32'(empty), 32'h3);
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, 3'd5, 6'h3F, 2'b00);
        chk("lit_badvc_count", 32'(count), 0);
        chk("lit_badvc_err", 32'(error), 0);

        // Randomized traffic with alternating fill/drain bias
        for (int c = 0; c < 2400; c++) begin
            if ((c / 150) % 2 == 0) begin wp = 80; rp = 30; end
            else begin wp = 30; rp = 70; end
            if (c % 40 == 0) begin
                umbral_af = TW'($urandom);
                umbral_ae = TW'($urandom);
            end
            wr_enable = ($urandom_range(0, 99) < wp);
            wr_vc     = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 7))
                                                   : 3'($urandom_range(0, NV - 1));
            data_in   = DW'($urandom);
            for (int v = 0; v < NV; v++) rd_enable[v] = ($urandom_range(0, 99) < rp);
            init      = ($urandom_range(0, 199) != 0);
            @(posedge clk);
            #1;
        end
        wr_enable = 1'b0;
        rd_enable = '0;
        init      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
